tdc_rx_deser: RTL
=================

// Module: tdc_rx_deser
// PURPOSE
// - Firmware-side receiver for the serial DATA_OUT stream of tdc_top (RX_DATA); directly downstream of the DUT.
// - Oversamples the line on CLK, frames and checks each word, and buffers the words in a small FIFO.
// - Presents words to the fw readout logic over a valid/ready handshake, with saturating error/overflow counters.
// PARAMETERS
// - DATA_W      16  payload bits per frame
// - CLK_DIV     10  CLK cycles per serial bit; even, >=4
// - FIFO_DEPTH  8   words buffered; power of 2, >=2
// - CNT_W       8   width of the saturating status counters
// PORTS
// - CLK             in   1                        system clock; the only clock
// - RESETB          in   1                        synchronous, active-low reset
// - ENABLE          in   1                        receiver enable; low aborts the current frame
// - CLR_CNT         in   1                        one-cycle pulse, clears all status counters
// - RX_DATA         in   1                        serial line from tdc_top DATA_OUT, idle high
// - DATA            out  DATA_W                   head-of-FIFO word
// - DATA_VALID      out  1                        DATA is valid
// - DATA_READY      in   1                        consumer accepts DATA when VALID&&READY
// - FIFO_COUNT      out  $clog2(FIFO_DEPTH)+1     words currently held
// - BUSY            out  1                        FSM not in IDLE
// - OVERFLOW_CNT    out  CNT_W                    words dropped because the FIFO was full
// - PARITY_ERR_CNT  out  CNT_W                    frames dropped on a parity mismatch
// - FRAME_ERR_CNT   out  CNT_W                    frames dropped on a bad stop bit
// BEHAVIOUR
// - Reset (RESETB low at a CLK edge): all outputs 0, FSM=IDLE, FIFO empty, synchroniser flops=1.
// - Frame format, in order:
//   - start bit 0
//   - DATA_W data bits, MSB first
//   - one even-parity bit (XOR of the data bits)
//   - stop bit 1
// - RX_DATA goes through a 2-FF synchroniser (2-cycle delay); the FSM uses the synchronised bit rx_s only.
// - FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE. Sample counter cnt counts down. "Sample" = cnt==0.
// - IDLE: on an rx_s falling edge with ENABLE=1, go to START with cnt=CLK_DIV/2-1 (mid-bit sampling).
// - START: at the sample, rx_s=1 is a false start -> IDLE, no error. rx_s=0 -> DATA, cnt=CLK_DIV-1, bit index=0.
// - DATA: at each sample, shift rx_s in MSB-first and reload cnt. After DATA_W samples go to PARITY.
// - PARITY: at the sample, latch par_err = rx_s ^ (^shift) and go to STOP.
// - STOP, at the sample:
//   - rx_s=0: FRAME_ERR_CNT++, go to WAIT_IDLE. Frame error takes priority over a parity error in the same frame.
//   - rx_s=1 and par_err: PARITY_ERR_CNT++, go to IDLE.
//   - rx_s=1, no par_err: push the word, go to IDLE.
// - WAIT_IDLE: stay until rx_s=1, then go to IDLE. This prevents resync on a stuck-low line.
// - ENABLE=0 in any state: FSM is in IDLE on the next cycle and the partial word is discarded. FIFO contents and counters are kept.
// - Push onto a full FIFO: word dropped, OVERFLOW_CNT++.
//   - A pop in the same cycle does NOT make room; the full check uses the pre-edge count.
// - FIFO is first-word-fall-through:
//   - Word pushed at stop-sample edge T gives DATA_VALID=1 with that word from cycle T+1.
//   - Minimum latency, RX_DATA stop-bit centre to DATA_VALID: 2 (sync) + 1 cycles.
// - Pop on DATA_VALID&&DATA_READY. DATA/DATA_VALID are stable while VALID=1 and READY=0.
// - Push and pop in the same cycle on a non-full FIFO: count unchanged; both are performed.
// - Counters saturate at 2**CNT_W-1. CLR_CNT has priority over a simultaneous increment (result is 0).
// - Reset mid-frame: same as power-on reset. FIFO is flushed.
// - Back-to-back frames (stop bit followed directly by a start bit): the next falling edge is detected from IDLE without a lost frame.
// STRUCTURE
// - Package tdc_rx_pkg holds:
//   - state enum rx_state_t {IDLE,START,DATA,PARITY,STOP,WAIT_IDLE}
//   - localparams START_BIT=1'b0 and STOP_BIT=1'b1
//   - function even_parity(DATA_W)
// - Sub-module tdc_rx_fifo (FWFT, parameters DATA_W/DEPTH; ports push, pop, din, dout, empty, full, count).
//   - Same CLK and RESETB.
// - tdc_rx_deser contains the synchroniser, the FSM, the shift register and the counters.
// TESTING
// - Word 16'hA5C3, CLK_DIV=10, correct parity/stop, READY=1 -> DATA=16'hA5C3 and VALID pulses 1 cycle, counters stay 0.
// - 9 frames 16'h0001..16'h0009 with READY=0:
//   - FIFO_COUNT=8 and OVERFLOW_CNT=1.
//   - Then READY=1 pops 0001..0008 in order.
// - Frame 16'h1234 with the parity bit flipped -> nothing pushed, PARITY_ERR_CNT=1. The next good 16'h5678 is received.
// - Frame with stop bit 0, then line held low for 50 cycles:
//   - FRAME_ERR_CNT=1, FSM stays in WAIT_IDLE, no push.
//   - After release, frame 16'hBEEF is received.
// - 3-cycle low glitch on idle line -> false start, BUSY returns to 0, no push, no counter change.
// - ENABLE=0 mid-DATA of frame 16'hFFFF -> no push, BUSY=0 next cycle.
//   - CLR_CNT issued together with an overflow increment -> counter reads 0.

Source files
------------

// File: rtl/tdc_rx_pkg.sv
// Shared types and constants for the TDC serial-stream receiver.
// Holds the receiver FSM state encoding and the frame bit values.
package tdc_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Widest payload the parity helper accepts; narrower words zero-extend.
    localparam int PAR_MAX_W = 64;

    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/tdc_rx_fifo.sv
// First-word-fall-through word buffer for the TDC receiver.
// A push onto a full buffer is ignored; the caller counts the drop.
module tdc_rx_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic                     CLK,
    input  logic                     RESETB,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]     wr_q, wr_d;
    logic [AW-1:0]     rd_q, rd_d;
    logic [AW:0]       cnt_q, cnt_d;
    logic              do_push;
    logic              do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign count   = cnt_q;
    assign dout    = mem_q[rd_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) begin
            mem_d[wr_q] = din;
            wr_d        = wr_q + 1'b1;
        end
        if (do_pop) begin
            rd_d = rd_q + 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Register storage and pointers; reset flushes and zeroes the head word.
    always_ff @(posedge CLK) begin
        if (!RESETB) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tdc_rx_deser.sv
// Serial receiver for the tdc_top DATA_OUT stream: sync, frame, check,
// buffer, and count dropped words with saturating status counters.
module tdc_rx_deser
    import tdc_rx_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int CLK_DIV    = 10,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 8
) (
    input  logic                          CLK,
    input  logic                          RESETB,
    input  logic                          ENABLE,
    input  logic                          CLR_CNT,
    input  logic                          RX_DATA,
    output logic [DATA_W-1:0]             DATA,
    output logic                          DATA_VALID,
    input  logic                          DATA_READY,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT,
    output logic                          BUSY,
    output logic [CNT_W-1:0]              OVERFLOW_CNT,
    output logic [CNT_W-1:0]              PARITY_ERR_CNT,
    output logic [CNT_W-1:0]              FRAME_ERR_CNT
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int BW = $clog2(DATA_W);
    localparam logic [CW-1:0]    CNT_FULL = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]    CNT_HALF = CW'(CLK_DIV / 2 - 1);
    localparam logic [BW-1:0]    BIT_LAST = BW'(DATA_W - 1);
    localparam logic [CNT_W-1:0] SAT_MAX  = '1;

    logic              rx_meta_q, rx_meta_d;
    logic              rx_s_q, rx_s_d;
    logic              rx_prev_q, rx_prev_d;
    rx_state_t         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_err_q, par_err_d;
    logic [CNT_W-1:0]  ovf_q, ovf_d;
    logic [CNT_W-1:0]  perr_q, perr_d;
    logic [CNT_W-1:0]  ferr_q, ferr_d;
    logic              sample;
    logic              push;
    logic              perr_inc;
    logic              ferr_inc;
    logic              ovf_inc;
    logic              fifo_empty;
    logic              fifo_full;

    assign sample         = (cnt_q == '0);
    assign ovf_inc        = push && fifo_full;
    assign DATA_VALID     = !fifo_empty;
    assign BUSY           = (state_q != IDLE);
    assign OVERFLOW_CNT   = ovf_q;
    assign PARITY_ERR_CNT = perr_q;
    assign FRAME_ERR_CNT  = ferr_q;

    // Two-stage synchroniser plus a delayed copy for falling-edge detect.
    always_comb begin
        rx_meta_d = RX_DATA;
        rx_s_d    = rx_meta_q;
        rx_prev_d = rx_s_q;
    end

    // Frame FSM: mid-bit sampling, MSB-first shift, parity and stop checks.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_err_d = par_err_q;
        push      = 1'b0;
        perr_inc  = 1'b0;
        ferr_inc  = 1'b0;
        if (!ENABLE) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (rx_prev_q && !rx_s_q) begin
                        state_d = START;
                        cnt_d   = CNT_HALF;
                    end
                end
                START: begin
                    if (!sample) begin
                        cnt_d = cnt_q - 1'b1;
                    end else if (rx_s_q == START_BIT) begin
                        state_d = tdc_rx_pkg::DATA;
                        cnt_d   = CNT_FULL;
                        bit_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                tdc_rx_pkg::DATA: begin
                    if (!sample) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        shift_d = {shift_q[DATA_W-2:0], rx_s_q};
                        cnt_d   = CNT_FULL;
                        bit_d   = bit_q + 1'b1;
                        if (bit_q == BIT_LAST) begin
                            state_d = PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (!sample) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        par_err_d = rx_s_q ^ even_parity(PAR_MAX_W'(shift_q));
                        cnt_d     = CNT_FULL;
                        state_d   = STOP;
                    end
                end
                STOP: begin
                    if (!sample) begin
                        cnt_d = cnt_q - 1'b1;
                    end else if (rx_s_q != STOP_BIT) begin
                        ferr_inc = 1'b1;
                        state_d  = WAIT_IDLE;
                    end else if (par_err_q) begin
                        perr_inc = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end
                end
                WAIT_IDLE: begin
                    if (rx_s_q) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Saturating status counters; a clear beats a same-cycle increment.
    always_comb begin
        ovf_d  = ovf_q;
        perr_d = perr_q;
        ferr_d = ferr_q;
        if (CLR_CNT) begin
            ovf_d  = '0;
            perr_d = '0;
            ferr_d = '0;
        end else begin
            if (ovf_inc && ovf_q != SAT_MAX) ovf_d = ovf_q + 1'b1;
            if (perr_inc && perr_q != SAT_MAX) perr_d = perr_q + 1'b1;
            if (ferr_inc && ferr_q != SAT_MAX) ferr_d = ferr_q + 1'b1;
        end
    end

    // State registers; synchroniser resets to the idle-high line level.
    always_ff @(posedge CLK) begin
        if (!RESETB) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_err_q <= 1'b0;
            ovf_q     <= '0;
            perr_q    <= '0;
            ferr_q    <= '0;
        end else begin
            rx_meta_q <= rx_meta_d;
            rx_s_q    <= rx_s_d;
            rx_prev_q <= rx_prev_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_err_q <= par_err_d;
            ovf_q     <= ovf_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

    tdc_rx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .CLK    (CLK),
        .RESETB (RESETB),
        .push   (push),
        .pop    (DATA_READY),
        .din    (shift_q),
        .dout   (DATA),
        .empty  (fifo_empty),
        .full   (fifo_full),
        .count  (FIFO_COUNT)
    );

endmodule
